// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the repeated-subtraction divider.
//   div_state_e   : controller state encoding (3 bits, IDLE = 0)
//   DIV_WIDTH_DEF : default operand/result width
package div_pkg;

  localparam int DIV_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    SUB  = 3'd3,
    DONE = 3'd4
  } div_state_e;

endpackage : div_pkg

// File: rtl/div_datapath.sv
// div_datapath: registers and arithmetic for the repeated-subtraction divider.
// Holds the dividend/remainder, the divisor, the quotient counter and the
// divide-by-zero flag; all updates are commanded by the controller.
// Optional build macro: DIV_FASTSUB_EN (adds a double-step subtract path).
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   data_i         : shared operand bus
//   load_a_i       : capture dividend into the remainder register
//   load_b_i       : capture divisor, clear quotient and dbz flag
//   step1_i        : rem -= divisor, quot += 1
//   step2_i        : rem -= 2*divisor, quot += 2 (DIV_FASTSUB_EN only)
//   set_dbz_i      : flag divide-by-zero, force quotient to all ones
//   quot_o, rem_o  : quotient / remainder registers
//   dbz_o          : divide-by-zero flag register
//   ge1_o          : rem >= divisor
//   ge2_o          : rem >= 2*divisor (DIV_FASTSUB_EN only)
//   dvz_o          : divisor == 0
module div_datapath #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             load_a_i,
  input  logic             load_b_i,
  input  logic             step1_i,
`ifdef DIV_FASTSUB_EN
  input  logic             step2_i,
  output logic             ge2_o,
`endif
  input  logic             set_dbz_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             dbz_o,
  output logic             ge1_o,
  output logic             dvz_o
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic             dbz_q, dbz_d;

  assign ge1_o = (rem_q >= div_q);
  assign dvz_o = (div_q == '0);

`ifdef DIV_FASTSUB_EN
  // Doubled divisor kept one bit wider so the compare never sees a wrapped value.
  logic [WIDTH:0] dbl_div;
  assign dbl_div = {div_q, 1'b0};
  assign ge2_o   = ({1'b0, rem_q} >= dbl_div);
`endif

  always_comb begin
    rem_d  = rem_q;
    div_d  = div_q;
    quot_d = quot_q;
    dbz_d  = dbz_q;
    if (load_a_i) begin
      rem_d = data_i;
    end
    if (load_b_i) begin
      div_d  = data_i;
      quot_d = '0;
      dbz_d  = 1'b0;
    end
    if (set_dbz_i) begin
      dbz_d  = 1'b1;
      quot_d = '1;
    end
    if (step1_i) begin
      rem_d  = rem_q - div_q;
      quot_d = quot_q + WIDTH'(1);
    end
`ifdef DIV_FASTSUB_EN
    // Only asserted when rem >= 2*divisor, so the low WIDTH bits suffice.
    if (step2_i) begin
      rem_d  = rem_q - dbl_div[WIDTH-1:0];
      quot_d = quot_q + WIDTH'(2);
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      div_q  <= '0;
      quot_q <= '0;
      dbz_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      div_q  <= div_d;
      quot_q <= quot_d;
      dbz_q  <= dbz_d;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;
  assign dbz_o  = dbz_q;

endmodule : div_datapath

// File: rtl/div_repsub.sv
// div_repsub: sequential unsigned divider by repeated subtraction.
// Operands arrive on data_in on the two cycles after start is sampled
// (dividend, then divisor). Quotient, remainder and the divide-by-zero
// flag are held while done is high.
// Optional build macro: DIV_FASTSUB_EN (subtract twice the divisor when
// possible, roughly halving the iteration count; results unchanged).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : begin an operation (honoured only in IDLE or DONE)
//   data_in   : operand bus
//   quot, rem : quotient / remainder, valid while done
//   done      : high in DONE
//   busy      : high in LDA, LDB, SUB
//   dbz       : divide-by-zero flag, valid while done
module div_repsub
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             done,
  output logic             busy,
  output logic             dbz
);

  div_state_e state_q, state_d;

  logic load_a, load_b, step1, set_dbz;
  logic ge1, dvz;
`ifdef DIV_FASTSUB_EN
  logic step2, ge2;
`endif

  div_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk_i     (clk),
    .rst_i     (rst),
    .data_i    (data_in),
    .load_a_i  (load_a),
    .load_b_i  (load_b),
    .step1_i   (step1),
`ifdef DIV_FASTSUB_EN
    .step2_i   (step2),
    .ge2_o     (ge2),
`endif
    .set_dbz_i (set_dbz),
    .quot_o    (quot),
    .rem_o     (rem),
    .dbz_o     (dbz),
    .ge1_o     (ge1),
    .dvz_o     (dvz)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LDA;
      LDA:     state_d = LDB;
      LDB:     state_d = SUB;
      SUB: begin
        // A zero divisor exits at once; otherwise iterate while rem >= divisor.
        if (dvz || !ge1) state_d = DONE;
      end
      DONE:    if (start) state_d = LDA;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath-control decode
  always_comb begin
    load_a  = (state_q == LDA);
    load_b  = (state_q == LDB);
    set_dbz = (state_q == SUB) && dvz;
`ifdef DIV_FASTSUB_EN
    // ge2 implies ge1 whenever the divisor is nonzero, so the two steps
    // are mutually exclusive.
    step2   = (state_q == SUB) && !dvz && ge2;
    step1   = (state_q == SUB) && !dvz && ge1 && !ge2;
`else
    step1   = (state_q == SUB) && !dvz && ge1;
`endif
    done    = (state_q == DONE);
    busy    = (state_q == LDA) || (state_q == LDB) || (state_q == SUB);
  end

endmodule : div_repsub

// File: tb/tb_div_repsub.sv
module tb_div_repsub;

  localparam int W = 16;
`ifdef DIV_FASTSUB_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] data_in;
  logic [W-1:0] quot, rem;
  logic         done, busy, dbz;

  always #5 clk = ~clk;

  div_repsub #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .quot    (quot),
    .rem     (rem),
    .done    (done),
    .busy    (busy),
    .dbz     (dbz)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  longint edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  // Reference model: current expected operation
  bit           m_active = 1'b0;
  longint       m_c0;
  int           m_lat;
  logic [W-1:0] m_q, m_r;
  logic         m_dbz;

  function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned q;
    if (b == 0) return 4;
    q = int'(a) / int'(b);
    if (FAST) return int'(q / 2 + q % 2) + 4;
    return int'(q) + 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin : cmp
    longint e;
    if (!rst && chk_en) begin
      if (!m_active) begin
        chk("idle_done", {31'd0, done}, 0);
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_quot", {16'd0, quot}, 0);
        chk("idle_rem",  {16'd0, rem}, 0);
        chk("idle_dbz",  {31'd0, dbz}, 0);
      end else begin
        e = edge_cnt - m_c0 + 1;
        if (e < longint'(m_lat)) begin
          chk("run_busy", {31'd0, busy}, 1);
          chk("run_done", {31'd0, done}, 0);
        end else begin
          chk("res_busy", {31'd0, busy}, 0);
          chk("res_done", {31'd0, done}, 1);
          chk("res_quot", {16'd0, quot}, {16'd0, m_q});
          chk("res_rem",  {16'd0, rem},  {16'd0, m_r});
          chk("res_dbz",  {31'd0, dbz},  {31'd0, m_dbz});
        end
      end
    end
  end

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    @(negedge clk);
    start   = 1'b1;
    data_in = W'($urandom);
    @(posedge clk);
    #1;
    m_c0  = edge_cnt;
    m_lat = model_lat(a, b);
    if (b == 0) begin
      m_q = '1; m_r = a; m_dbz = 1'b1;
    end else begin
      m_q = a / b; m_r = a % b; m_dbz = 1'b0;
    end
    m_active = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    data_in = a;
    @(negedge clk);
    data_in = b;
  endtask

  task automatic finish_op(output int lat);
    lat = -1;
    for (int k = 0; k < m_lat + 10; k++) begin
      @(negedge clk);
      data_in = W'($urandom);
      if (done === 1'b1) begin
        lat = int'(edge_cnt - m_c0 + 1);
        break;
      end
    end
    start = 1'b0;
    if (lat < 0) chk("done_timeout", 0, 1);
    else chk("latency", lat, m_lat);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    launch(a, b, 1'b0);
    finish_op(lat);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [W-1:0] a, b;
    rst = 1'b1; start = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quot", {16'd0, quot}, 0);
    chk("rst_rem",  {16'd0, rem}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_dbz",  {31'd0, dbz}, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases with hand-computed results
    run_op(16'd100, 16'd7, lat);
    chk("d100_7_quot", {16'd0, quot}, 14);
    chk("d100_7_rem",  {16'd0, rem}, 2);
    chk("d100_7_dbz",  {31'd0, dbz}, 0);
    chk("d100_7_lat",  lat, FAST ? 11 : 18);

    run_op(16'd5, 16'd9, lat);
    chk("d5_9_quot", {16'd0, quot}, 0);
    chk("d5_9_rem",  {16'd0, rem}, 5);
    chk("d5_9_lat",  lat, 4);

    run_op(16'd0, 16'd3, lat);
    chk("d0_3_quot", {16'd0, quot}, 0);
    chk("d0_3_rem",  {16'd0, rem}, 0);

    run_op(16'd1234, 16'd0, lat);
    chk("dbz_flag", {31'd0, dbz}, 1);
    chk("dbz_quot", {16'd0, quot}, 32'hFFFF);
    chk("dbz_rem",  {16'd0, rem}, 1234);
    chk("dbz_lat",  lat, 4);

    run_op(16'd65535, 16'd1, lat);
    chk("dmax_quot", {16'd0, quot}, 65535);
    chk("dmax_rem",  {16'd0, rem}, 0);
    chk("dmax_lat",  lat, FAST ? 32772 : 65539);

    // Asynchronous reset in the middle of SUB
    launch(16'd1000, 16'd3, 1'b0);
    repeat (20) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    m_active = 1'b0;
    #1;
    chk("arst_quot", {16'd0, quot}, 0);
    chk("arst_rem",  {16'd0, rem}, 0);
    chk("arst_done", {31'd0, done}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_dbz",  {31'd0, dbz}, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_op(16'd48, 16'd6, lat);
    chk("d48_6_quot", {16'd0, quot}, 8);
    chk("d48_6_rem",  {16'd0, rem}, 0);

    // start held high through the whole operation
    launch(16'd20, 16'd4, 1'b1);
    finish_op(lat);
    chk("hold_quot", {16'd0, quot}, 5);
    chk("hold_rem",  {16'd0, rem}, 0);
    repeat (5) @(negedge clk);
    chk("hold_done_stays", {31'd0, done}, 1);

    launch(16'd9, 16'd2, 1'b0);
    chk("restart_done_low", {31'd0, done}, 0);
    finish_op(lat);
    chk("d9_2_quot", {16'd0, quot}, 4);
    chk("d9_2_rem",  {16'd0, rem}, 1);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0: begin a = W'($urandom_range(0, 300));   b = W'($urandom_range(0, 20)); end
        1: begin a = W'($urandom);                 b = W'($urandom_range(256, 65535)); end
        default: begin b = W'($urandom_range(0, 65535)); a = W'($urandom_range(0, int'(b))); end
      endcase
      run_op(a, b, lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_div_repsub

// File: doc/div_repsub.md
Name: div_repsub

Overview:
- Sequential unsigned integer divider using repeated subtraction. It is the inverse companion of the repeated-addition multiplier.
- Operands arrive over the shared data_in bus in two consecutive cycles: dividend first, then divisor.
- Uses the same start/done handshake as the multiplier. Controller FSM and datapath are split as in the multiplier.
- Returns quotient and remainder, and flags divide-by-zero.

Parameters:
- WIDTH, 16, operand/result width in bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin operation; sampled only in IDLE or DONE
- data_in  input  WIDTH  operand bus: dividend in the cycle after start is sampled, divisor in the cycle after that
- quot  output  WIDTH  quotient register; valid while done=1
- rem  output  WIDTH  remainder register; valid while done=1
- done  output  1  high while in DONE
- busy  output  1  high in LDA, LDB, SUB
- dbz  output  1  divide-by-zero flag; valid while done=1

Behaviour:
- Reset (async, rst=1): state=IDLE; quot=0, rem=0, divisor reg=0; done=0, busy=0, dbz=0. Reset mid-operation aborts it immediately with no partial result retained.
- States and transitions:
  - IDLE: start=1 -> LDA.
  - LDA: rem <= data_in (dividend); -> LDB.
  - LDB: divisor <= data_in; quot <= 0; dbz <= 0; -> SUB.
  - SUB, checked in priority order each cycle:
    - divisor==0: dbz <= 1, quot <= all ones, rem unchanged; -> DONE.
    - rem >= divisor: rem <= rem - divisor, quot <= quot + 1; stay in SUB.
    - otherwise: -> DONE.
  - DONE: results held. start=1 -> LDA (new operation, done drops next cycle). Otherwise stay.
- done, busy and dbz are decoded from registered state and flags, so they carry no combinational path from inputs.
- start is ignored in LDA, LDB and SUB.
- Latency: done rises Q+4 clock edges after the edge that samples start, where Q is the quotient. Divisor 0 gives 4 edges.
- Arithmetic is unsigned WIDTH bits. The compare is unsigned. quot cannot overflow because quot <= dividend when divisor >= 1.
- Boundaries:
  - dividend < divisor: quot=0, rem=dividend.
  - dividend=0: quot=0, rem=0 (or dbz if divisor=0).
  - divisor=1: maximum latency, 2^WIDTH+3 edges for an all-ones dividend.
- Data on data_in outside the LDA and LDB cycles is don't-care.

Optional Feature:
- Macro: DIV_FASTSUB_EN.
- Defined: SUB first checks rem >= 2*divisor, computed at WIDTH+1 bits so the doubled value cannot overflow. If true, rem <= rem - 2*divisor and quot <= quot + 2. Otherwise the single-step rule above applies.
  - Step count becomes floor(Q/2) + (Q mod 2).
  - Results are identical to the undefined case.
- Undefined: single-step subtraction only, as specified above.

Decomposition:
- Package div_pkg:
  - state enum: IDLE, LDA, LDB, SUB, DONE; 3-bit encoding, IDLE=0.
  - DIV_WIDTH_DEF = 16.
- One sub-module, div_datapath:
  - dividend/remainder register, divisor register, quotient counter;
  - subtractor(s) and comparator(s);
  - exports ge1, ge2 (DIV_FASTSUB_EN only) and dvz compare results.
- The top-level div_repsub holds the FSM and drives the load and step enables.

Test Plan:
- 100/7: start, data_in=100 then 7 -> quot=14, rem=2, dbz=0. done after 18 edges (11 with DIV_FASTSUB_EN).
- 5/9 -> quot=0, rem=5, done after 4 edges. 0/3 -> quot=0, rem=0.
- 1234/0 -> dbz=1, quot=16'hFFFF, rem=1234, done after 4 edges.
- 65535/1 -> quot=65535, rem=0. done after 65539 edges (32772 with DIV_FASTSUB_EN).
- rst pulsed mid-SUB of 1000/3 -> all outputs 0 and state IDLE without waiting for a clock. Then 48/6 -> quot=8, rem=0.
- start held high through 20/4: operands loaded once, quot=5, rem=0.
  - done stays high while start=0.
  - Pulse start with 9 then 2: done drops next cycle, then quot=4, rem=1.
